// File: rtl/switch_pkg.sv
// switch_pkg: shared cell constants, frame descriptor type and padding helper for the switch datapath.
package switch_pkg;
    localparam int CELL_WORDS = 8;
    localparam int WORD_IDX_W = 9;

    typedef struct packed {
        logic [WORD_IDX_W-1:0] words;
        logic [3:0]            bytes;
        logic                  drop;
    } seg_desc_t;

    function automatic logic [2:0] pad_from_words(input logic [WORD_IDX_W-1:0] words);
        return 3'(CELL_WORDS - int'(words % WORD_IDX_W'(CELL_WORDS)));
    endfunction
endpackage

// File: rtl/seg_sync_fifo.sv
// seg_sync_fifo: single-clock first-word-fall-through FIFO with full/empty flags.
module seg_sync_fifo #(
    parameter int W = 64,
    parameter int D = 512
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rd,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(D);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_wr, do_rd;

    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign full  = cnt == (AW+1)'(D);
    assign empty = cnt == '0;
    assign dout  = mem[rp];

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk)
        if (do_wr) mem[wp] <= din;

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/switch_pre_segmenter.sv
// switch_pre_segmenter: store-and-forward AXIS frame buffer emitting fixed 8-word cells.
// Optional oversize-frame dropping is built when SWITCH_PRE_OVERSIZE_DROP_EN is defined.
module switch_pre_segmenter
    import switch_pkg::*;
#(
    parameter int MAX_FRAME_WORDS = 192,
    parameter int DATA_DEPTH      = 512,
    parameter int DESC_DEPTH      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    output logic        cell_data_wr,
    output logic [63:0] cell_data_din,
    output logic        cell_first,
    output logic        cell_last,
    output logic [2:0]  pad_num_64,
    output logic [3:0]  vaild,
    input  logic        cell_bp,
    output logic [15:0] ovs_drop_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, EMIT, GAP} state_t;

    if (DATA_DEPTH < MAX_FRAME_WORDS + CELL_WORDS) begin : g_depth_check
        $error("DATA_DEPTH must hold a maximum frame plus one cell");
    end

    state_t                state, state_nx;
    seg_desc_t             desc_in, desc_head;
    logic [63:0]           data_head;
    logic                  data_full, data_empty, desc_full, desc_empty;
    logic                  hs, over, data_wr, desc_wr, desc_pop, data_pop;
    logic                  emit, has_data, cell_end, frame_end, drop;
    logic [WORD_IDX_W-1:0] wcnt, words;
    logic [5:0]            cell_idx, last_cell;
    logic [2:0]            widx;
    logic [9:0]            cells_w;

    assign s_axis_tready = !reset && !data_full && !desc_full;
    assign hs            = s_axis_tvalid && s_axis_tready;
`ifdef SWITCH_PRE_OVERSIZE_DROP_EN
    assign over = wcnt == WORD_IDX_W'(MAX_FRAME_WORDS);
`else
    assign over = 1'b0;
`endif
    assign data_wr = hs && !over;
    assign desc_wr = hs && s_axis_tlast;
    assign desc_in = '{words: over ? wcnt : wcnt + 1'b1,
                       bytes: 4'($countones(s_axis_tkeep)),
                       drop:  over};

    seg_sync_fifo #(.W(64), .D(DATA_DEPTH)) u_data (
        .clk(clk), .reset(reset), .wr(data_wr), .din(s_axis_tdata), .rd(data_pop),
        .dout(data_head), .full(data_full), .empty(data_empty)
    );

    seg_sync_fifo #(.W($bits(seg_desc_t)), .D(DESC_DEPTH)) u_desc (
        .clk(clk), .reset(reset), .wr(desc_wr), .din(desc_in), .rd(desc_pop),
        .dout(desc_head), .full(desc_full), .empty(desc_empty)
    );

    // Ingress word counter; saturates on oversize frames so the length stays clamped
    always_ff @(posedge clk)
        wcnt <= reset ? '0 : !hs ? wcnt : s_axis_tlast ? '0 : over ? wcnt : wcnt + 1'b1;

    assign cells_w   = ({1'b0, desc_head.words} + 10'd7) >> 3;
    assign emit      = state == EMIT;
    assign has_data  = {cell_idx, widx} < words;
    assign cell_end  = widx == 3'd7;
    assign frame_end = cell_end && cell_idx == last_cell;
    assign data_pop  = emit && has_data && !data_empty;

    // Egress next-state: backpressure is only honoured before a frame and between cells
    always_comb begin
        state_nx = state;
        desc_pop = 1'b0;
        case (state)
            IDLE:    state_nx = (!desc_empty && !cell_bp) ? LOAD : IDLE;
            LOAD: begin
                desc_pop = 1'b1;
                state_nx = EMIT;
            end
            EMIT:    state_nx = frame_end ? IDLE : (cell_end && cell_bp) ? GAP : EMIT;
            GAP:     state_nx = cell_bp ? GAP : EMIT;
            default: state_nx = IDLE;
        endcase
    end

    // Egress state and per-frame context latched from the descriptor
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            words      <= '0;
            last_cell  <= '0;
            drop       <= 1'b0;
            cell_idx   <= '0;
            widx       <= '0;
            pad_num_64 <= '0;
            vaild      <= '0;
        end else begin
            state <= state_nx;
            if (state == LOAD) begin
                words      <= desc_head.words;
                last_cell  <= 6'(cells_w - 10'd1);
                drop       <= desc_head.drop;
                cell_idx   <= '0;
                widx       <= '0;
                pad_num_64 <= pad_from_words(desc_head.words);
                vaild      <= desc_head.bytes;
            end else if (emit) begin
                widx <= widx + 1'b1;
                if (cell_end) cell_idx <= cell_idx + 1'b1;
            end
        end
    end

    // Registered cell word outputs; words past the frame end are zero padding
    always_ff @(posedge clk) begin
        if (reset) begin
            cell_data_wr  <= 1'b0;
            cell_data_din <= '0;
            cell_first    <= 1'b0;
            cell_last     <= 1'b0;
        end else begin
            cell_data_wr  <= emit && !drop;
            cell_data_din <= (emit && has_data) ? data_head : '0;
            cell_first    <= emit && cell_idx == '0;
            cell_last     <= emit && cell_idx == last_cell;
        end
    end

`ifdef SWITCH_PRE_OVERSIZE_DROP_EN
    // Count each oversize frame once its stored words have been discarded
    always_ff @(posedge clk)
        if (reset) ovs_drop_cnt <= '0;
        else if (emit && frame_end && drop && ovs_drop_cnt != '1) ovs_drop_cnt <= ovs_drop_cnt + 1'b1;
`else
    assign ovs_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_switch_pre_segmenter.sv
// tb_switch_pre_segmenter: directed self-checking bench for the cell pre-segmenter.
module tb_switch_pre_segmenter;
    logic        clk = 0;
    logic        reset = 1;
    logic        s_axis_tvalid = 0;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 0;
    logic        cell_data_wr;
    logic [63:0] cell_data_din;
    logic        cell_first, cell_last;
    logic [2:0]  pad_num_64;
    logic [3:0]  vaild;
    logic        cell_bp = 0;
    logic [15:0] ovs_drop_cnt;

    typedef struct {
        logic [63:0] d;
        logic        f;
        logic        l;
        logic [2:0]  p;
        logic [3:0]  v;
        int          c;
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    int  stalls = 0;
    int  total = 0;
    int  bad = 0;

    switch_pre_segmenter dut (
        .clk(clk), .reset(reset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .cell_data_wr(cell_data_wr), .cell_data_din(cell_data_din),
        .cell_first(cell_first), .cell_last(cell_last),
        .pad_num_64(pad_num_64), .vaild(vaild),
        .cell_bp(cell_bp), .ovs_drop_cnt(ovs_drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (cell_data_wr) q.push_back('{cell_data_din, cell_first, cell_last, pad_num_64, vaild, cyc});
    end

    always @(negedge clk)
        if (s_axis_tvalid && !s_axis_tready && !reset) stalls++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    function automatic logic [63:0] exp_data(input int i, input int n, input logic [63:0] base);
        return (i < n) ? base + 64'(i) : 64'h0;
    endfunction

    task automatic send(input int n, input logic [7:0] lk, input logic [63:0] base, input bit with_last);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            s_axis_tvalid = 1;
            s_axis_tdata  = base + 64'(i);
            s_axis_tlast  = with_last && i == n - 1;
            s_axis_tkeep  = s_axis_tlast ? lk : 8'hFF;
            while (!s_axis_tready && g < 500) begin
                @(negedge clk);
                g++;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        s_axis_tvalid = 0;
        s_axis_tlast  = 0;
    endtask

    task automatic wait_writes(input int n);
        int g = 0;
        while (q.size() < n && g < 2000) begin
            @(negedge clk);
            g++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        total++;
        if (s_axis_tready !== 1'b0) begin
            bad++;
            $display("FAIL reset_tready got=%b exp=0", s_axis_tready);
        end
        total++;
        if ({cell_data_wr, cell_data_din, cell_first, cell_last, pad_num_64, vaild} !== '0) begin
            bad++;
            $display("FAIL reset_cell_outputs got wr=%b d=%h f=%b l=%b p=%0d v=%0d exp all 0",
                     cell_data_wr, cell_data_din, cell_first, cell_last, pad_num_64, vaild);
        end
        total++;
        if (ovs_drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_ovs got=%0d exp=0", ovs_drop_cnt);
        end
        reset = 0;
        @(negedge clk);
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset got=%b exp=1", s_axis_tready);
        end
    endtask

    task automatic test_single_cell();
        logic [63:0] base = 64'h1111_0000_0000_0000;
        q.delete();
        send(8, 8'hFF, base, 1);
        idle();
        wait_writes(8);
        total++;
        if (q.size() !== 8) begin
            bad++;
            $display("FAIL single_cell_count got=%0d exp=8", q.size());
        end
        for (int i = 0; i < q.size() && i < 8; i++) begin
            total++;
            if ({q[i].d, q[i].f, q[i].l, q[i].p, q[i].v} !== {exp_data(i, 8, base), 1'b1, 1'b1, 3'd0, 4'd8}) begin
                bad++;
                $display("FAIL single_cell_w%0d got d=%h f=%b l=%b p=%0d v=%0d exp d=%h f=1 l=1 p=0 v=8",
                         i, q[i].d, q[i].f, q[i].l, q[i].p, q[i].v, exp_data(i, 8, base));
            end
        end
    endtask

    task automatic test_two_cell();
        logic [63:0] base = 64'h2222_0000_0000_0100;
        q.delete();
        send(9, 8'h01, base, 1);
        idle();
        wait_writes(16);
        total++;
        if (q.size() !== 16) begin
            bad++;
            $display("FAIL two_cell_count got=%0d exp=16", q.size());
        end
        for (int i = 0; i < q.size() && i < 16; i++) begin
            logic ef, el;
            ef = i < 8;
            el = i >= 8;
            total++;
            if ({q[i].d, q[i].f, q[i].l, q[i].p, q[i].v} !== {exp_data(i, 9, base), ef, el, 3'd7, 4'd1}) begin
                bad++;
                $display("FAIL two_cell_w%0d got d=%h f=%b l=%b p=%0d v=%0d exp d=%h f=%b l=%b p=7 v=1",
                         i, q[i].d, q[i].f, q[i].l, q[i].p, q[i].v, exp_data(i, 9, base), ef, el);
            end
        end
    endtask

    task automatic test_partial_keep();
        logic [63:0] base = 64'hA5A5_5A5A_DEAD_BE00;
        q.delete();
        send(8, 8'h0F, base, 1);
        idle();
        wait_writes(8);
        total++;
        if (q.size() !== 8) begin
            bad++;
            $display("FAIL keep_count got=%0d exp=8", q.size());
        end
        for (int i = 0; i < q.size() && i < 8; i++) begin
            total++;
            if ({q[i].d, q[i].f, q[i].l, q[i].p, q[i].v} !== {exp_data(i, 8, base), 1'b1, 1'b1, 3'd0, 4'd4}) begin
                bad++;
                $display("FAIL keep_w%0d got d=%h f=%b l=%b p=%0d v=%0d exp d=%h f=1 l=1 p=0 v=4",
                         i, q[i].d, q[i].f, q[i].l, q[i].p, q[i].v, exp_data(i, 8, base));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] base = 64'h3333_0000_0000_0200;
        int g = 0;
        int k;
        q.delete();
        send(20, 8'h3F, base, 1);
        idle();
        while (q.size() == 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        cell_bp = 1;
        repeat (10) @(negedge clk);
        total++;
        if (q.size() !== 8) begin
            bad++;
            $display("FAIL bp_hold_count got=%0d exp=8", q.size());
        end
        k = cyc;
        cell_bp = 0;
        wait_writes(24);
        total++;
        if (q.size() !== 24) begin
            bad++;
            $display("FAIL bp_total_count got=%0d exp=24", q.size());
        end
        total++;
        if (q.size() > 8 && q[8].c !== k + 2) begin
            bad++;
            $display("FAIL bp_release_latency got=%0d exp=%0d", q[8].c - k, 2);
        end
        for (int i = 0; i < q.size() && i < 24; i++) begin
            logic ef, el;
            ef = i < 8;
            el = i >= 16;
            total++;
            if ({q[i].d, q[i].f, q[i].l, q[i].p, q[i].v} !== {exp_data(i, 20, base), ef, el, 3'd4, 4'd6}) begin
                bad++;
                $display("FAIL bp_w%0d got d=%h f=%b l=%b p=%0d v=%0d exp d=%h f=%b l=%b p=4 v=6",
                         i, q[i].d, q[i].f, q[i].l, q[i].p, q[i].v, exp_data(i, 20, base), ef, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] b1 = 64'h4444_0000_0000_0000;
        logic [63:0] b2 = 64'h5555_0000_0000_0000;
        q.delete();
        stalls = 0;
        send(8, 8'hFF, b1, 1);
        send(8, 8'hFF, b2, 1);
        idle();
        total++;
        if (stalls !== 0) begin
            bad++;
            $display("FAIL b2b_ready_stalls got=%0d exp=0", stalls);
        end
        wait_writes(16);
        total++;
        if (q.size() !== 16) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=16", q.size());
        end
        total++;
        if (q.size() == 16 && q[8].c - q[7].c !== 3) begin
            bad++;
            $display("FAIL b2b_frame_gap got=%0d exp=3", q[8].c - q[7].c);
        end
        for (int i = 0; i < q.size() && i < 16; i++) begin
            logic [63:0] ed;
            ed = (i < 8) ? b1 + 64'(i) : b2 + 64'(i - 8);
            total++;
            if ({q[i].d, q[i].f, q[i].l} !== {ed, 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL b2b_w%0d got d=%h f=%b l=%b exp d=%h f=1 l=1", i, q[i].d, q[i].f, q[i].l, ed);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] base = 64'h6666_0000_0000_0000;
        q.delete();
        send(5, 8'hFF, 64'hBAD0_0000_0000_0000, 0);
        idle();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        send(8, 8'hFF, base, 1);
        idle();
        wait_writes(8);
        total++;
        if (q.size() !== 8) begin
            bad++;
            $display("FAIL midreset_count got=%0d exp=8", q.size());
        end
        for (int i = 0; i < q.size() && i < 8; i++) begin
            total++;
            if (q[i].d !== base + 64'(i)) begin
                bad++;
                $display("FAIL midreset_w%0d got=%h exp=%h", i, q[i].d, base + 64'(i));
            end
        end
    endtask

`ifdef SWITCH_PRE_OVERSIZE_DROP_EN
    task automatic test_oversize();
        logic [63:0] base = 64'h7777_0000_0000_0000;
        q.delete();
        send(300, 8'hFF, 64'hBAD1_0000_0000_0000, 1);
        send(8, 8'hFF, base, 1);
        idle();
        wait_writes(8);
        total++;
        if (q.size() !== 8) begin
            bad++;
            $display("FAIL ovs_count got=%0d exp=8", q.size());
        end
        total++;
        if (ovs_drop_cnt !== 16'd1) begin
            bad++;
            $display("FAIL ovs_drop_cnt got=%0d exp=1", ovs_drop_cnt);
        end
        for (int i = 0; i < q.size() && i < 8; i++) begin
            total++;
            if ({q[i].d, q[i].f, q[i].l} !== {base + 64'(i), 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL ovs_w%0d got d=%h f=%b l=%b exp d=%h f=1 l=1", i, q[i].d, q[i].f, q[i].l, base + 64'(i));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_cell();
        test_two_cell();
        test_partial_keep();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
`ifdef SWITCH_PRE_OVERSIZE_DROP_EN
        test_oversize();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/switch_pre_segmenter.md
# switch_pre_segmenter

Ingress stage of the switch datapath; it sits directly upstream of the cell-to-frame reassembler. It accepts Ethernet frames on a 64-bit AXI4-Stream slave and buffers each frame in full (store-and-forward). It then emits the frame as fixed 8-word cells on the cell-write interface: per-word first/last-cell flags, padding-word count and last-word valid-byte count. It obeys the downstream cell backpressure at cell granularity.

## Interface
- MAX_FRAME_WORDS, 192, largest accepted frame in 64-bit words (1536 B)
- DATA_DEPTH, 512, data buffer depth in words; must be ≥ MAX_FRAME_WORDS + 8
- DESC_DEPTH, 32, frame-descriptor buffer depth
- clk  in  1  clock; reset is synchronous, active-high (`reset`)
- reset  in  1  synchronous active-high reset
- s_axis_tvalid  in  1  frame word valid
- s_axis_tready  out  1  frame word accepted
- s_axis_tdata  in  64  frame data, byte 0 in [7:0]
- s_axis_tkeep  in  8  byte enables; LSB-contiguous, must be 0xFF except on the tlast word
- s_axis_tlast  in  1  last word of frame
- cell_data_wr  out  1  cell word strobe
- cell_data_din  out  64  cell word
- cell_first  out  1  word belongs to first cell of frame
- cell_last  out  1  word belongs to last cell of frame
- pad_num_64  out  3  padding words in last cell (0..7), constant over frame
- vaild  out  4  valid bytes in last data word (1..8), constant over frame
- cell_bp  in  1  downstream cell buffer backpressure
- ovs_drop_cnt  out  16  oversize frames dropped (saturating)

## Operation
- Ingress: s_axis_tready = !reset & data buffer not full & descriptor buffer not full. Each handshake writes tdata into the data buffer and increments a 9-bit word counter.
- On the tlast handshake, push descriptor {words[8:0], bytes = popcount(tkeep)[3:0], drop}. Clear the word counter.
- Derived per frame: cells = ceil(words/8); pad = (8 − words mod 8) mod 8.
- Egress FSM:
  - IDLE: if descriptor available and !cell_bp, go to LOAD.
  - LOAD: pop the descriptor; latch cells, pad, bytes; clear word index; go to EMIT.
  - EMIT: one word per cycle. Index < words: output the buffer head and pop it. Otherwise output 64'h0.
    - cell_first = (cell index == 0); cell_last = (cell index == cells−1).
    - At word 7 of a cell: last cell → IDLE; cell_bp → GAP; else next cell.
  - GAP: wait until cell_bp is low, then go to EMIT.
- cell_bp is sampled only at cell boundaries. A cell once started always completes its 8 words.
- Single-cell frame: cell_first = cell_last = 1 on all 8 words.
- Reset mid-frame: both buffers are flushed, the FSM goes to IDLE, and partial frames are lost.

## Timing
- Reset values: s_axis_tready 0, cell_data_wr 0, cell_data_din 0, cell_first 0, cell_last 0, pad_num_64 0, vaild 0, ovs_drop_cnt 0.
- All cell outputs are registered.
- Ingress throughput is 1 word/cycle. tready drops the cycle after the buffer reaches full.
- tlast handshake at cycle T: descriptor visible at T+1, LOAD at T+2, first cell_data_wr at T+3.
- Egress throughput is 1 word/cycle. Back-to-back cells have zero gap when cell_bp is low. Back-to-back frames have a 2-cycle gap (IDLE, LOAD).
- When cell_bp is released in GAP, the next cell's first word appears 1 cycle after low is sampled.
- Simultaneous tlast write and LOAD pop on the descriptor buffer must both succeed.

## Configuration
- SWITCH_PRE_OVERSIZE_DROP_EN defined:
  - Words beyond MAX_FRAME_WORDS are accepted and discarded, not written. The descriptor's drop bit is set and words is saturated to MAX_FRAME_WORDS.
  - In EMIT, the FSM pops the stored words with cell_data_wr low, then increments ovs_drop_cnt.
- Undefined: no length check is made and the drop bit is always 0. ovs_drop_cnt is tied to 0. Frames > MAX_FRAME_WORDS are an upstream protocol violation with undefined behaviour.

## Structure
- Shared package switch_pkg holds:
  - CELL_WORDS = 8
  - WORD_IDX_W = 9
  - struct seg_desc_t {words, bytes, drop}
  - function pad_from_words()
- One sub-module, seg_sync_fifo (parameterised width/depth, first-word-fall-through, full/empty). It is instantiated twice: data (64 b × DATA_DEPTH) and descriptor (seg_desc_t × DESC_DEPTH).

## Test plan
- 8 words, last tkeep 0xFF → 8 writes, first=last=1, pad_num_64=0, vaild=8.
- 9 words, last tkeep 0x01 → 16 writes.
  - Words 1–8: first=1, last=0.
  - Words 9–16: first=0, last=1; words 10–16 are 0.
  - pad=7, vaild=1 on all 16.
- 8 words, last tkeep 0x0F → pad_num_64=0, vaild=4; data bytes pass unmodified.
- 20-word frame, cell_bp high during cell 0 for 10 cycles:
  - Cell 0 completes.
  - No writes while cell_bp is high.
  - Cell 1 starts 1 cycle after cell_bp is low.
  - 24 writes total, pad=4.
- Two back-to-back 8-word frames with continuous tvalid → tready stays 1; the second frame's cell starts 2 cycles after the first frame's word 8.
- With SWITCH_PRE_OVERSIZE_DROP_EN: 300-word frame then 8-word frame → no writes for the first frame, ovs_drop_cnt=1, second frame emitted intact.
